grant_mux_stage: RTL

- Sits directly downstream of the 4-way round-robin arbiter and consumes its registered one-hot grant.
- Latches the grant to select one of four source channels and moves that source's packet through a valid/ready output register until the last beat.
- Holds ownership for the whole packet and raises busy so upstream logic can mask arbiter requests.
- Forms the data path that follows arbitration in the shared-resource interconnect.

---
 rtl/grant_mux_pkg.sv | 33 +++
 rtl/out_reg_slice.sv | 58 +++++
 rtl/grant_mux_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/grant_mux_pkg.sv
// +------------------------------------------------------------------+
// | grant_mux_pkg : shared types, sizes and grant helpers             |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

package grant_mux_pkg;

  localparam int N_SRC     = 4;
  localparam int SRC_IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic logic is_onehot(input logic [N_SRC-1:0] v);
    return (v != '0) && ((v & (v - {{(N_SRC-1){1'b0}}, 1'b1})) == '0);
  endfunction

  // Highest set bit wins; callers qualify with is_onehot first.
  function automatic logic [SRC_IDX_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
    logic [SRC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (oh[i]) idx = SRC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_reg_slice.sv
// +------------------------------------------------------------------+
// | out_reg_slice : 1-entry valid/ready register for {data,last,src}  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

module out_reg_slice
  import grant_mux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SRC_W  = SRC_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [SRC_W-1:0]  i_src,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [SRC_W-1:0]  o_src
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [SRC_W-1:0]  r_src;

  // Empty or draining this cycle: a new beat may replace the current one.
  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_src   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_src   <= i_src;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_src   = r_src;

endmodule

`default_nettype wire

// File: rtl/grant_mux_stage.sv
// +------------------------------------------------------------------+
// | grant_mux_stage : grant-owned packet mux behind the RR arbiter     |
// | Optional idle abort enabled by macro GRANT_TIMEOUT_EN              |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

module grant_mux_stage #(
  parameter int DATA_W  = 32,
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  grant,
  input  logic [N_SRC-1:0]                  src_valid,
  input  logic [N_SRC*DATA_W-1:0]           src_data,
  input  logic [N_SRC-1:0]                  src_last,
  output logic [N_SRC-1:0]                  src_ready,
  output logic                              out_valid,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_last,
  output logic [grant_mux_pkg::SRC_IDX_W-1:0] out_src,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              grant_err,
  output logic                              timeout
);

  import grant_mux_pkg::*;

  localparam logic [0:0] c_ST_IDLE = IDLE;
  localparam logic [0:0] c_ST_XFER = XFER;

  logic [0:0]           r_state;
  logic [SRC_IDX_W-1:0] r_owner;
  logic                 r_grant_err;

  logic                 w_xfer;
  logic                 w_can_load;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [DATA_W-1:0]    w_sel_data;

  assign w_xfer      = (r_state == c_ST_XFER);
  assign w_sel_valid = src_valid[r_owner];
  assign w_sel_last  = src_last[r_owner];
  assign w_sel_data  = src_data[int'(r_owner)*DATA_W +: DATA_W];
  assign w_accept    = w_xfer && w_sel_valid && w_can_load;

  always_comb begin
    src_ready = '0;
    if (w_xfer) src_ready[r_owner] = w_sel_valid && w_can_load;
  end

`ifdef GRANT_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_idle_cnt;
  logic               r_timeout;

  // Abort on the edge that would bring the idle count to TIMEOUT.
  assign w_abort = w_xfer && !w_accept && (r_idle_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_abort;
      if (!w_xfer || w_accept || w_abort) r_idle_cnt <= '0;
      else                                r_idle_cnt <= r_idle_cnt + c_CNT_W'(1);
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT == 0);
  assign w_abort = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_owner     <= '0;
      r_grant_err <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (grant != '0) begin
            if (is_onehot(grant)) begin
              r_owner <= onehot_to_idx(grant);
              r_state <= c_ST_XFER;
            end else begin
              r_grant_err <= 1'b1;
            end
          end
        end
        c_ST_XFER: begin
          if ((w_accept && w_sel_last) || w_abort) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  out_reg_slice #(
    .DATA_W (DATA_W),
    .SRC_W  (SRC_IDX_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_data     (w_sel_data),
    .i_last     (w_sel_last),
    .i_src      (r_owner),
    .i_ready    (out_ready),
    .o_can_load (w_can_load),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_last     (out_last),
    .o_src      (out_src)
  );

  assign busy      = w_xfer;
  assign grant_err = r_grant_err;

endmodule

`default_nettype wire
